prbs_gen: RTL and testbench



---
 rtl/prbs_pkg.sv | 50 +++++
 rtl/prbs_checker.sv | 100 ++++++++++
 rtl/prbs_gen.sv | 104 ++++++++++
 tb/tb_prbs_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared constants, polynomial codes and tap helpers for the PRBS generator and its loopback checker.
package prbs_pkg;

    localparam int LFSR_MAX     = 31;
    localparam int LOCK_MATCHES = 32;
    localparam int UNLOCK_ERRS  = 4;
    localparam int CTRL_EN_BIT  = 7;
    localparam int CTRL_INV_BIT = 6;

    localparam logic [LFSR_MAX-1:0] SEED = '1;

    typedef enum logic [2:0] {
        POLY_PRBS7  = 3'd0,
        POLY_PRBS9  = 3'd1,
        POLY_PRBS15 = 3'd2,
        POLY_PRBS23 = 3'd3,
        POLY_PRBS31 = 3'd4
    } poly_e;

    typedef enum logic {
        CHK_HUNT   = 1'b0,
        CHK_LOCKED = 1'b1
    } chk_state_e;

    // Tap indices per polynomial, indexed by poly_e; TAP_HI is also N-1.
    localparam int TAP_HI [5] = '{6, 8, 14, 22, 30};
    localparam int TAP_LO [5] = '{5, 4, 13, 17, 27};

    function automatic poly_e decode_poly(input logic [2:0] sel);
        poly_e p;
        case (sel)
            3'd1:    p = POLY_PRBS9;
            3'd2:    p = POLY_PRBS15;
            3'd3:    p = POLY_PRBS23;
            3'd4:    p = POLY_PRBS31;
            default: p = POLY_PRBS7;
        endcase
        return p;
    endfunction

    function automatic logic tap_fb(input logic [LFSR_MAX-1:0] r, input poly_e p);
        return r[TAP_HI[int'(p)]] ^ r[TAP_LO[int'(p)]];
    endfunction

    // Ones in the low N bits of the selected polynomial.
    function automatic logic [LFSR_MAX-1:0] low_mask(input poly_e p);
        return SEED >> (LFSR_MAX - 1 - TAP_HI[int'(p)]);
    endfunction

endpackage

// File: rtl/prbs_checker.sv
// Self-synchronising loopback checker: HUNT/LOCKED FSM, private shift register, saturating error count.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LFSR_WIDTH = LFSR_MAX
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  poly_chg,
    input  poly_e                 poly,
    input  logic                  inv,
    input  logic                  stb,
    input  logic                  chk_i,
    output logic [DATA_WIDTH-1:0] err_cnt_o,
    output chk_state_e            state_o
);

    chk_state_e            state_q, state_d;
    logic [4:0]            match_q, match_d;
    logic [1:0]            miss_q, miss_d;
    logic [LFSR_WIDTH-1:0] sreg_q;
    logic [DATA_WIDTH-1:0] err_q;
    logic                  expected;
    logic                  mismatch;
    logic                  err_inc;

    // The register holds raw (possibly inverted) bits; XOR of two inverted taps cancels the inversion.
    assign expected = tap_fb(sreg_q, poly) ^ inv;
    assign mismatch = (chk_i != expected);

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_inc = 1'b0;
        if (!en || poly_chg) begin
            state_d = CHK_HUNT;
            match_d = '0;
            miss_d  = '0;
        end else if (stb) begin
            case (state_q)
                CHK_HUNT: begin
                    if (mismatch) begin
                        match_d = '0;
                    end else if (match_q == 5'(LOCK_MATCHES - 1)) begin
                        state_d = CHK_LOCKED;
                        match_d = '0;
                        miss_d  = '0;
                    end else begin
                        match_d = match_q + 5'd1;
                    end
                end
                CHK_LOCKED: begin
                    err_inc = mismatch;
                    if (!mismatch) begin
                        miss_d = '0;
                    end else if (miss_q == 2'(UNLOCK_ERRS - 1)) begin
                        state_d = CHK_HUNT;
                        miss_d  = '0;
                        match_d = '0;
                    end else begin
                        miss_d = miss_q + 2'd1;
                    end
                end
                default: state_d = CHK_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CHK_HUNT;
            match_q <= '0;
            miss_q  <= '0;
            sreg_q  <= SEED;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            if (!en || poly_chg) begin
                sreg_q <= SEED;
            end else if (stb) begin
                sreg_q <= {sreg_q[LFSR_WIDTH-2:0], chk_i};
            end
            // Poly change drops lock but keeps the count; only disable clears it.
            if (!en) begin
                err_q <= '0;
            end else if (err_inc && (err_q != '1)) begin
                err_q <= err_q + 1'b1;
            end
        end
    end

    assign err_cnt_o = err_q;
    assign state_o   = state_q;

endmodule

// File: rtl/prbs_gen.sv
// Programmable PRBS generator: bit-rate divider, Fibonacci LFSR, reseed logic.
// Optional loopback checker compiled in when PRBS_CHECKER_EN is defined.
module prbs_gen
    import prbs_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LFSR_WIDTH = LFSR_MAX
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] cfg_div,
    input  logic [DATA_WIDTH-1:0] cfg_ctrl,
    output logic                  prbs_o,
    output logic                  bit_stb_o,
    input  logic                  chk_i,
    output logic [DATA_WIDTH-1:0] err_cnt_o,
    output logic                  lock_o
);

    logic                  en;
    logic                  inv;
    poly_e                 poly;
    logic [2:0]            sel_q;
    logic                  poly_chg;
    logic [DATA_WIDTH-1:0] div_cnt;
    logic [LFSR_WIDTH-1:0] lfsr;
    logic                  strobe;
    logic                  fb;
    logic                  zero_state;
    logic                  prbs_q;
    logic                  stb_q;
    logic                  unused_ctrl;

    assign en          = cfg_ctrl[CTRL_EN_BIT];
    assign inv         = cfg_ctrl[CTRL_INV_BIT];
    assign poly        = decode_poly(cfg_ctrl[2:0]);
    assign poly_chg    = (cfg_ctrl[2:0] != sel_q);
    assign unused_ctrl = ^cfg_ctrl[5:3];

    // >= rather than == so a shrinking cfg_div strobes at once instead of wrapping.
    assign strobe     = (div_cnt >= cfg_div);
    assign fb         = tap_fb(lfsr, poly);
    assign zero_state = ((lfsr & low_mask(poly)) == '0);

    // Previous-cycle select, tracked unconditionally so reset never looks like a change.
    always_ff @(posedge clk) begin
        sel_q <= cfg_ctrl[2:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            div_cnt <= '0;
            lfsr    <= SEED;
            prbs_q  <= 1'b0;
            stb_q   <= 1'b0;
        end else if (poly_chg) begin
            div_cnt <= '0;
            lfsr    <= SEED;
            stb_q   <= 1'b0;
        end else if (strobe) begin
            div_cnt <= '0;
            stb_q   <= 1'b1;
            prbs_q  <= fb ^ inv;
            lfsr    <= zero_state ? SEED : {lfsr[LFSR_WIDTH-2:0], fb};
        end else begin
            div_cnt <= div_cnt + 1'b1;
            stb_q   <= 1'b0;
        end
    end

    // bit_stb_o is high for exactly the one cycle in which prbs_o carries a freshly
    // shifted bit; a consumer samples prbs_o (or the looped-back chk_i) only then.
    assign prbs_o    = prbs_q;
    assign bit_stb_o = stb_q;

`ifdef PRBS_CHECKER_EN
    chk_state_e chk_state;

    prbs_checker #(
        .DATA_WIDTH (DATA_WIDTH),
        .LFSR_WIDTH (LFSR_WIDTH)
    ) u_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .poly_chg  (poly_chg),
        .poly      (poly),
        .inv       (inv),
        .stb       (stb_q),
        .chk_i     (chk_i),
        .err_cnt_o (err_cnt_o),
        .state_o   (chk_state)
    );

    assign lock_o = (chk_state == CHK_LOCKED);
`else
    logic unused_chk;

    assign unused_chk = chk_i;
    assign err_cnt_o  = '0;
    assign lock_o     = 1'b0;
`endif

endmodule

// File: tb/tb_prbs_gen.sv
// Self-checking bench for prbs_gen: scoreboard of expected bits from a reference LFSR model.
// Checker scenarios run when PRBS_CHECKER_EN is defined.
module tb_prbs_gen;

    logic       clk;
    logic       rst_n;
    logic [7:0] cfg_div;
    logic [7:0] cfg_ctrl;
    logic       prbs_o;
    logic       bit_stb_o;
    logic       chk_i;
    logic [7:0] err_cnt_o;
    logic       lock_o;
    logic       flip;

    int n_chk;
    int n_err;

    logic        exp_q[$];
    logic        cap_q[$];
    logic [30:0] m_state;

    prbs_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_div   (cfg_div),
        .cfg_ctrl  (cfg_ctrl),
        .prbs_o    (prbs_o),
        .bit_stb_o (bit_stb_o),
        .chk_i     (chk_i),
        .err_cnt_o (err_cnt_o),
        .lock_o    (lock_o)
    );

    assign chk_i = prbs_o ^ flip;

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: Fibonacci LFSR, taps chosen from the polynomial table.
    task automatic model_push(input logic [7:0] ctrl, input int n);
        int   hi;
        int   lo;
        logic fb;
        case (ctrl[2:0])
            3'd1:    begin hi = 8;  lo = 4;  end
            3'd2:    begin hi = 14; lo = 13; end
            3'd3:    begin hi = 22; lo = 17; end
            3'd4:    begin hi = 30; lo = 27; end
            default: begin hi = 6;  lo = 5;  end
        endcase
        for (int i = 0; i < n; i++) begin
            fb      = m_state[hi] ^ m_state[lo];
            m_state = {m_state[29:0], fb};
            exp_q.push_back(fb ^ ctrl[6]);
        end
    endtask

    // Pops one expected bit per strobe; checks bit value, strobe spacing and hold between strobes.
    task automatic monitor(input int div, input int n);
        int   cyc;
        int   last;
        int   budget;
        logic b;
        logic prev;
        cyc    = 0;
        last   = 0;
        prev   = 1'b0;
        budget = n * (div + 1) + 20;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bit_stb_o) begin
                b = exp_q.pop_front();
                check("bit", 32'(prbs_o), 32'(b));
                check("stb_gap", cyc - last, div + 1);
                last = cyc;
                prev = prbs_o;
                cap_q.push_back(prbs_o);
            end else if (div > 0) begin
                check("hold", 32'(prbs_o), 32'(prev));
            end
        end
        if (exp_q.size() != 0) begin
            check("timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic run(input int div, input logic [7:0] ctrl, input int n);
        @(negedge clk);
        cfg_div  = 8'(div);
        cfg_ctrl = ctrl & 8'h7f;
        @(negedge clk);
        m_state = '1;
        cap_q.delete();
        model_push(ctrl, n);
        cfg_ctrl = ctrl;
        monitor(div, n);
    endtask

    task automatic check_first7(input string tag, input logic [6:0] bits, input int base);
        if (cap_q.size() < base + 7) begin
            check({tag, "_len"}, cap_q.size(), base + 7);
        end else begin
            for (int i = 0; i < 7; i++) begin
                check(tag, 32'(cap_q[base + i]), 32'(bits[i]));
            end
        end
    endtask

    initial begin
        logic [6:0] p7;
        logic [6:0] p7_inv;
        int         ones;
        n_chk    = 0;
        n_err    = 0;
        flip     = 1'b0;
        rst_n    = 1'b0;
        cfg_div  = 8'd0;
        cfg_ctrl = 8'h00;
        p7       = 7'b1000000;
        p7_inv   = 7'b0111111;

        repeat (3) @(negedge clk);
        check("rst_prbs", 32'(prbs_o), 0);
        check("rst_stb", 32'(bit_stb_o), 0);
        check("rst_err", 32'(err_cnt_o), 0);
        check("rst_lock", 32'(lock_o), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("dis_stb", 32'(bit_stb_o), 0);

        // PRBS7, one bit per clock, beyond one full period
        run(0, 8'h80, 134);
        check_first7("p7_first", p7, 0);
        check_first7("p7_period", p7, 127);

        // PRBS7 inverted, 4 clocks per bit
        run(3, 8'hC0, 10);
        check_first7("p7_inv", p7_inv, 0);

        // PRBS31 first 31 bits
        run(0, 8'h84, 31);
        ones = 0;
        foreach (cap_q[i]) ones += int'(cap_q[i]);
        check("p31_nonzero", 32'(ones != 0), 1);

        // enable dropped for one cycle mid-sequence
        run(0, 8'h80, 20);
        cfg_ctrl = 8'h00;
        @(negedge clk);
        check("drop_prbs", 32'(prbs_o), 0);
        check("drop_stb", 32'(bit_stb_o), 0);
        m_state = '1;
        cap_q.delete();
        model_push(8'h80, 7);
        cfg_ctrl = 8'h80;
        monitor(0, 7);
        check_first7("drop_restart", p7, 0);

        // randomised divider on PRBS9, then inverted PRBS23
        run($urandom_range(1, 5), 8'h81, 20);
        run(0, 8'hC3, 30);

`ifdef PRBS_CHECKER_EN
        run(0, 8'h82, 32);
        check("lock_early", 32'(lock_o), 0);
        @(negedge clk);
        check("lock_32", 32'(lock_o), 1);
        check("err_clean", 32'(err_cnt_o), 0);
        repeat (20) @(negedge clk);
        check("err_still0", 32'(err_cnt_o), 0);
        flip = 1'b1;
        @(negedge clk);
        flip = 1'b0;
        repeat (40) @(negedge clk);
        check("err_inject", 32'(err_cnt_o), 3);
        check("lock_held", 32'(lock_o), 1);
`else
        check("nochk_err", 32'(err_cnt_o), 0);
        check("nochk_lock", 32'(lock_o), 0);
`endif

        // reset mid-run, then sequence restarts from the seed
        rst_n    = 1'b0;
        cfg_ctrl = 8'h82;
        cfg_div  = 8'd0;
        @(negedge clk);
        check("mrst_prbs", 32'(prbs_o), 0);
        check("mrst_stb", 32'(bit_stb_o), 0);
        check("mrst_err", 32'(err_cnt_o), 0);
        check("mrst_lock", 32'(lock_o), 0);
        m_state = '1;
        cap_q.delete();
        model_push(8'h82, 15);
        rst_n = 1'b1;
        monitor(0, 15);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
